// File: rtl/shift_add_mult8_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package shift_add_mult8_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult8_bit8_adder.sv
// Ripple-carry adder: purely combinational, zero latency, no backpressure.
// The multiplier uses it as its only arithmetic element.
module bit8_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier, one add per clock.
// Latency WIDTH+1 edges start-to-done; start is ignored while busy (not queued).
module shift_add_mult8
  import shift_add_mult8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] shifted;

  assign addend = acc_lo[0] ? mcand : '0;

  bit8_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry rides into the top bit of the shifted accumulator so it is never lost.
  assign shifted = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST_CNT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          {acc_hi, acc_lo} <= shifted;
          cnt              <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) product <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_add_mult8.sv
// Self-checking bench for shift_add_mult8 against plain a*b arithmetic.
module tb_shift_add_mult8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks   = 0;
  int failures = 0;

  shift_add_mult8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and watch 12 edges: done edge index, done count, busy cycles.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        output int done_edge, output int ndone,
                        output int nbusy, output logic [15:0] prod);
    a = ia; b = ib; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    done_edge = -1; ndone = 0; nbusy = busy ? 1 : 0; prod = 16'hxxxx;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_edge < 0) begin
          done_edge = i;
          prod = product;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (product !== 16'h0000) begin failures++; $display("FAIL reset_product got=%h want=0000", product); end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'hFF, 8'hAA, 8'h01, 8'h00};
    logic [7:0] tb [4] = '{8'hFF, 8'h55, 8'h80, 8'hC3};
    logic [15:0] want;
    int de, nd, nb;
    logic [15:0] p;
    for (int k = 0; k < 4; k++) begin
      want = 16'(ta[k]) * 16'(tb[k]);
      run_op(ta[k], tb[k], de, nd, nb, p);
      checks++; if (p !== want) begin failures++; $display("FAIL directed_product[%0d] got=%h want=%h", k, p, want); end
      checks++; if (de != 8) begin failures++; $display("FAIL directed_latency[%0d] got=%0d want=8", k, de); end
      checks++; if (nd != 1) begin failures++; $display("FAIL directed_done_count[%0d] got=%0d want=1", k, nd); end
      checks++; if (nb != 9) begin failures++; $display("FAIL directed_busy_cycles[%0d] got=%0d want=9", k, nb); end
    end
  endtask

  task automatic test_start_while_busy();
    int nd = 0;
    a = 8'h12; b = 8'h34; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      // Edge 3 lands in RUN, edge 9 in DONE; both starts must be dropped.
      if (i == 3 || i == 9) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      step();
      start = 1'b0;
      if (done) nd++;
    end
    checks++; if (nd != 1) begin failures++; $display("FAIL busy_start_done_count got=%0d want=1", nd); end
    checks++; if (product !== 16'h03A8) begin failures++; $display("FAIL busy_start_product got=%h want=03a8", product); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int nd1 = 0, nd2 = 0, hold_bad = 0;
    bit seen2 = 0;
    a = 8'h10; b = 8'h10; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (done) nd1++;
    end
    checks++; if (product !== 16'h0100) begin failures++; $display("FAIL b2b_first_product got=%h want=0100", product); end
    checks++; if (nd1 != 1) begin failures++; $display("FAIL b2b_first_done_count got=%0d want=1", nd1); end
    a = 8'h03; b = 8'h05; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (done) begin nd2++; seen2 = 1; end
      else if (!seen2 && product !== 16'h0100) hold_bad++;
    end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL b2b_hold got=%0d_bad_cycles want=0", hold_bad); end
    checks++; if (product !== 16'h000F) begin failures++; $display("FAIL b2b_second_product got=%h want=000f", product); end
    checks++; if (nd2 != 1) begin failures++; $display("FAIL b2b_second_done_count got=%0d want=1", nd2); end
  endtask

  task automatic test_async_reset();
    int nd = 0, de, nb;
    logic [15:0] p;
    a = 8'h0A; b = 8'h0B; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b want=0", done); end
    checks++; if (product !== 16'h0000) begin failures++; $display("FAIL arst_product got=%h want=0000", product); end
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) nd++;
    end
    checks++; if (nd != 0) begin failures++; $display("FAIL arst_no_done got=%0d want=0", nd); end
    run_op(8'h07, 8'h09, de, nd, nb, p);
    checks++; if (p !== 16'h003F) begin failures++; $display("FAIL arst_fresh_product got=%h want=003f", p); end
    checks++; if (nd != 1) begin failures++; $display("FAIL arst_fresh_done_count got=%0d want=1", nd); end
  endtask

  task automatic test_random_sweep();
    logic [7:0]  ra, rb;
    logic [15:0] want, p;
    int de, nd, nb;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      want = 16'(ra) * 16'(rb);
      run_op(ra, rb, de, nd, nb, p);
      checks++; if (p !== want) begin failures++; $display("FAIL rand_product a=%h b=%h got=%h want=%h", ra, rb, p, want); end
      checks++; if (nd != 1) begin failures++; $display("FAIL rand_done_count a=%h b=%h got=%0d want=1", ra, rb, nd); end
      checks++; if (de != 8) begin failures++; $display("FAIL rand_latency a=%h b=%h got=%0d want=8", ra, rb, de); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    test_random_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
